// File: rtl/jtag_scan_master.sv
// jtag_scan_master: JTAG host that derives tclk/tms/tdi from clk and samples
// tdo. Runs one queued TAP operation at a time:
//   RESET    : 5x tms=1 then tms=0, leaves the TAP in Run-Test/Idle
//   IR_SCAN  : RTI -> Shift-IR, shift req_len bits, back to RTI
//   DR_SCAN  : RTI -> Shift-DR, shift req_len bits, back to RTI
//   RUN_IDLE : req_len TCKs with tms=0
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   req_valid/ready/op/len/data  request handshake (data LSB shifted first)
//   resp_valid/err/data      one-cycle completion pulse, captured tdo
//   tap_synced               TAP known to be in Run-Test/Idle
//   tclk, tms, tdi, tdo      JTAG pins
//   trst                     active-low TAP reset (only with JTAG_SCAN_TRST_EN)
// Optional feature macro: JTAG_SCAN_TRST_EN adds trst and pulses it low for
// one full TCK period before the RESET TMS sequence.
module jtag_scan_master #(
    parameter int MAX_LEN  = 41,
    parameter int HALF_DIV = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [$clog2(MAX_LEN+1)-1:0] req_len,
    input  logic [MAX_LEN-1:0]           req_data,
    output logic                         resp_valid,
    output logic                         resp_err,
    output logic [MAX_LEN-1:0]           resp_data,
    output logic                         tap_synced,
    output logic                         tclk,
    output logic                         tms,
    output logic                         tdi,
    input  logic                         tdo
`ifdef JTAG_SCAN_TRST_EN
    ,
    output logic                         trst
`endif
);

    localparam int LW = $clog2(MAX_LEN + 1);          // request length width
    localparam int CW = $clog2(MAX_LEN + 7);          // TCK index width
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DW = $clog2(2 * HALF_DIV);         // divider width

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    typedef enum logic [2:0] {IDLE, LOAD, TCK_LO, TCK_HI, DONE} state_t;

    state_t               state, state_nx;
    logic [1:0]           op_q;
    logic [LW-1:0]        len_q;
    logic [MAX_LEN-1:0]   data_q;
    logic [CW-1:0]        ntck_q, tck_idx;
    logic [DW-1:0]        div_cnt;

    // Number of TCKs before the first shift edge: RTI->SelDR->Cap->Shift.
    function automatic logic [CW-1:0] pre_len(input logic [1:0] op);
        return (op == OP_IR) ? CW'(4) : CW'(3);
    endfunction

    function automatic logic in_shift(input logic [1:0] op, input logic [LW-1:0] n,
                                      input logic [CW-1:0] k);
        logic [CW-1:0] p;
        p = pre_len(op);
        return (op == OP_IR || op == OP_DR) && (k >= p) && (k < p + CW'(n));
    endfunction

    // tms for TCK k: select bits high, exit on the last shift, then Update, RTI.
    function automatic logic tms_at(input logic [1:0] op, input logic [LW-1:0] n,
                                    input logic [CW-1:0] k);
        logic [CW-1:0] p;
        logic [CW-1:0] last;
        logic          r;
        p    = pre_len(op);
        last = p + CW'(n) - CW'(1);
        case (op)
            OP_RESET: r = (k < CW'(5));
            OP_RUN:   r = 1'b0;
            default:  r = (k < p - CW'(2)) || (k == last) || (k == last + CW'(1));
        endcase
        return r;
    endfunction

    logic               accept, req_err, scan_req;
    logic [CW-1:0]      req_ntck;
    logic [1:0]         sel_op;
    logic [LW-1:0]      sel_len;
    logic [MAX_LEN-1:0] sel_data;
    logic [CW-1:0]      idx_nx, boff, soff;
    logic               tms_nx, tdi_nx;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign scan_req  = (req_op == OP_IR) || (req_op == OP_DR);

    always_comb begin
        req_err = (scan_req && (req_len == '0 || req_len > LW'(MAX_LEN)))
               || (req_op == OP_RUN && req_len > LW'(MAX_LEN))
               || (req_op != OP_RESET && !tap_synced);
        case (req_op)
            OP_RESET: req_ntck = CW'(6);
            OP_IR:    req_ntck = CW'(req_len) + CW'(6);
            OP_DR:    req_ntck = CW'(req_len) + CW'(5);
            default:  req_ntck = CW'(req_len);
        endcase
    end

    // The first TCK is set up in the acceptance cycle, before op_q is loaded.
    always_comb begin
        sel_op   = (state == IDLE) ? req_op   : op_q;
        sel_len  = (state == IDLE) ? req_len  : len_q;
        sel_data = (state == IDLE) ? req_data : data_q;
        idx_nx   = (state == TCK_HI) ? tck_idx + CW'(1) : '0;
        boff     = idx_nx - pre_len(sel_op);
        tms_nx   = tms_at(sel_op, sel_len, idx_nx);
        tdi_nx   = in_shift(sel_op, sel_len, idx_nx) ? sel_data[IW'(boff)] : 1'b0;
        soff     = tck_idx - pre_len(op_q);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err || req_ntck == '0) state_nx = DONE;
`ifdef JTAG_SCAN_TRST_EN
                    else if (req_op == OP_RESET)   state_nx = LOAD;
`endif
                    else                           state_nx = TCK_LO;
                end
            end
            LOAD:   if (div_cnt == DW'(2 * HALF_DIV - 1)) state_nx = TCK_LO;
            TCK_LO: if (div_cnt == DW'(HALF_DIV - 1)) state_nx = TCK_HI;
            TCK_HI: begin
                if (div_cnt == DW'(HALF_DIV - 1))
                    state_nx = (tck_idx == ntck_q - CW'(1)) ? DONE : TCK_LO;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            len_q      <= '0;
            data_q     <= '0;
            ntck_q     <= '0;
            tck_idx    <= '0;
            div_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            tap_synced <= 1'b0;
            tclk       <= 1'b0;
            tms        <= 1'b1;
            tdi        <= 1'b0;
`ifdef JTAG_SCAN_TRST_EN
            trst       <= 1'b1;
`endif
        end else begin
            state      <= state_nx;
            div_cnt    <= (state_nx != state || state == IDLE) ? '0 : div_cnt + DW'(1);
            tclk       <= (state_nx == TCK_HI);
            resp_valid <= (state_nx == DONE);
`ifdef JTAG_SCAN_TRST_EN
            trst       <= (state_nx != LOAD);
`endif
            if (accept) begin
                op_q      <= req_op;
                len_q     <= req_len;
                data_q    <= req_data;
                ntck_q    <= req_ntck;
                tck_idx   <= '0;
                resp_err  <= req_err;
                resp_data <= '0;
                if (req_op == OP_RESET) tap_synced <= 1'b0;
            end
            if (state == TCK_HI && state_nx == TCK_LO) tck_idx <= tck_idx + CW'(1);
            // tms/tdi change only when a new low half-period begins.
            if (state_nx == TCK_LO && state != TCK_LO) begin
                tms <= tms_nx;
                tdi <= tdi_nx;
            end else if (state_nx == LOAD) begin
                tms <= 1'b1;
                tdi <= 1'b0;
            end
            // tdo is stable here; the TAP only moves it on the falling edge.
            if (state == TCK_HI && div_cnt == '0 && in_shift(op_q, len_q, tck_idx))
                resp_data[IW'(soff)] <= tdo;
            if (state == TCK_HI && state_nx == DONE && op_q == OP_RESET)
                tap_synced <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: drives jtag_scan_master (HALF_DIV=2) against a
// behavioural TAP model; expected responses go through a scoreboard queue.
module tb_jtag_scan_master;

    localparam int ML = 41;
    localparam int HD = 2;
    localparam int LW = $clog2(ML + 1);
`ifdef JTAG_SCAN_TRST_EN
    localparam int RST_TCK = 7;
`else
    localparam int RST_TCK = 6;
`endif
    localparam logic [ML-1:0] DMI_CAP = 41'h1_2345_6789_AB;
    localparam logic [ML-1:0] DMI_WR  = {7'h10, 32'h80000000, 2'b10};

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [LW-1:0] req_len;
    logic [ML-1:0] req_data;
    logic          resp_valid, resp_err;
    logic [ML-1:0] resp_data;
    logic          tap_synced, tclk, tms, tdi, tdo;
    logic          trst_m;
`ifdef JTAG_SCAN_TRST_EN
    logic          trst;
    assign trst_m = trst;
`else
    assign trst_m = 1'b1;
`endif

    jtag_scan_master #(.MAX_LEN(ML), .HALF_DIV(HD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_len(req_len), .req_data(req_data),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
        .tap_synced(tap_synced), .tclk(tclk), .tms(tms), .tdi(tdi), .tdo(tdo)
`ifdef JTAG_SCAN_TRST_EN
        , .trst(trst)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- TAP model ----------------
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t          tap_st = TLR;
    logic [5:0]    ir = 6'h01;
    logic [5:0]    ir_sr = 6'h0;
    logic [ML-1:0] dr_sr = '0;
    int            dr_len = 1;
    logic [ML-1:0] dmi = '0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tclk or negedge trst_m) begin
        if (!trst_m) begin
            tap_st <= TLR;
            ir     <= 6'h01;
        end else begin
            case (tap_st)
                TLR:   ir <= 6'h01;
                CAPIR: ir_sr <= 6'h01;
                SHIR:  ir_sr <= {tdi, ir_sr[5:1]};
                UPIR:  ir <= ir_sr;
                CAPDR: begin
                    if (ir == 6'h01)      begin dr_sr <= ML'(32'h1BEEF001); dr_len <= 32; end
                    else if (ir == 6'h11) begin dr_sr <= DMI_CAP; dr_len <= ML; end
                    else                  begin dr_sr <= '0; dr_len <= 1; end
                end
                SHDR:  dr_sr <= (dr_sr >> 1) | (ML'(tdi) << (dr_len - 1));
                UPDR:  if (ir == 6'h11) dmi <= dr_sr;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tclk)
        tdo <= (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;

    // ---------------- monitors ----------------
    int          edges = 0;
    logic [63:0] tms_hist = '0;
    always @(posedge tclk) begin
        edges    = edges + 1;
        tms_hist = {tms_hist[62:0], tms};
    end

    int trst_lo = 0;
    int trst_first = 0;
    always @(negedge clk) begin
        if (!trst_m) begin
            if (trst_lo == 0) trst_first = cyc;
            trst_lo = trst_lo + 1;
        end
    end

    typedef struct {
        logic          err;
        logic [ML-1:0] data;
        int            cyc;
        string         tag;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin : mon
        exp_t e;
        if (resp_valid) begin
            if (sb.size() == 0) chk("spurious_resp", resp_valid, 1'b0);
            else begin
                e = sb.pop_front();
                chk({e.tag, "_err"}, resp_err, e.err);
                chk({e.tag, "_data"}, resp_data, e.data);
                chk({e.tag, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input string tag, input logic [1:0] op, input int len,
                          input logic [ML-1:0] data, input logic err,
                          input logic [ML-1:0] exp_d, input int lat, input int exp_edges);
        int e0, n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, req_ready, 1'b1);
        e0 = edges;
        last_acc = cyc;
        req_valid = 1'b1; req_op = op; req_len = LW'(len); req_data = data;
        sb.push_back('{err, exp_d, cyc + lat, tag});
        @(negedge clk);
        req_valid = 1'b0; req_data = '0;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, 64'(sb.size()), 0);
            sb.delete();
        end
        chk({tag, "_edges"}, 64'(edges - e0), 64'(exp_edges));
    endtask

    initial begin
        int e0, n;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_len = '0; req_data = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_tclk", tclk, 1'b0);
        chk("rst_tms", tms, 1'b1);
        chk("rst_tdi", tdi, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_synced", tap_synced, 1'b0);
`ifdef JTAG_SCAN_TRST_EN
        chk("rst_trst", trst, 1'b1);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1'b1);

        run_op("dr_unsync", 2'd2, 32, ML'(32'hDEADBEEF), 1'b1, '0, 1, 0);
        chk("unsync_tms", tms, 1'b1);

        trst_lo = 0;
        run_op("reset", 2'd0, 0, '0, 1'b0, '0, 1 + 2 * HD * RST_TCK, 6);
        chk("reset_tms_seq", tms_hist[5:0], 6'b111110);
        chk("reset_synced", tap_synced, 1'b1);
        chk("reset_tap_rti", tap_st, RTI);
        chk("idle_tms", tms, 1'b0);
`ifdef JTAG_SCAN_TRST_EN
        chk("trst_low_cycles", 64'(trst_lo), 64'(2 * HD));
        chk("trst_first", 64'(trst_first), 64'(last_acc + 1));
`endif

        run_op("dr_len0", 2'd2, 0, ML'(1), 1'b1, '0, 1, 0);
        run_op("dr_len42", 2'd2, 42, ML'(1), 1'b1, '0, 1, 0);
        run_op("run_len42", 2'd3, 42, '0, 1'b1, '0, 1, 0);

        run_op("idcode", 2'd2, 32, ML'(32'hDEADBEEF), 1'b0, ML'(32'h1BEEF001), 1 + 4 * 37, 37);
        chk("idcode_tap_rti", tap_st, RTI);

        run_op("ir", 2'd1, 6, ML'(6'h11), 1'b0, ML'(6'h01), 1 + 4 * 12, 12);
        chk("ir_model", ir, 6'h11);
        run_op("dmi", 2'd2, 41, DMI_WR, 1'b0, DMI_CAP, 1 + 4 * 46, 46);
        chk("dmi_model", dmi, DMI_WR);
        chk("dmi_tap_rti", tap_st, RTI);

        run_op("run0", 2'd3, 0, '0, 1'b0, '0, 1, 0);
        run_op("run3", 2'd3, 3, '0, 1'b0, '0, 1 + 4 * 3, 3);

        // Abort a 41-bit DR scan at its 10th TCK.
        @(negedge clk);
        e0 = edges;
        req_valid = 1'b1; req_op = 2'd2; req_len = LW'(41); req_data = DMI_WR;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (edges - e0 < 10 && n < 500) begin @(negedge clk); n++; end
        chk("abort_reach_10", 64'(edges - e0), 64'd10);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tclk", tclk, 1'b0);
        chk("abort_tms", tms, 1'b1);
        chk("abort_synced", tap_synced, 1'b0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        run_op("reset2", 2'd0, 0, '0, 1'b0, '0, 1 + 2 * HD * RST_TCK, 6);
        chk("reset2_tap_rti", tap_st, RTI);
        run_op("idcode2", 2'd2, 32, '0, 1'b0, ML'(32'h1BEEF001), 1 + 4 * 37, 37);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
